// File: rtl/pattern_writer_pkg.sv
// Shared types and default sizes for the pattern memory loader.
package pattern_pkg;

    localparam int unsigned PAT_DEPTH = 16;
    localparam int unsigned PAT_AW    = 4;
    localparam int unsigned PAT_DW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } pw_state_t;

endpackage

// File: rtl/pattern_writer_if.sv
// Byte-stream input handshake plus the pattern memory port.
// master: the loader side; slave: the byte source and memory side.
interface pattern_writer_if
    import pattern_pkg::*;
#(
    parameter int unsigned AW = PAT_AW,
    parameter int unsigned DW = PAT_DW
) ();

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] RAM_addr;
    logic [DW-1:0] RAM_wdata;
    logic [DW-1:0] RAM_rdata;
    logic          RAM_we;
    logic          RAM_re;
    logic          RAM_ce;

    modport master (
        input  in_data, in_valid, RAM_rdata,
        output in_ready, RAM_addr, RAM_wdata, RAM_we, RAM_re, RAM_ce
    );

    modport slave (
        output in_data, in_valid, RAM_rdata,
        input  in_ready, RAM_addr, RAM_wdata, RAM_we, RAM_re, RAM_ce
    );

endinterface

// File: rtl/pattern_writer_byte_sum_acc.sv
// Modulo-2^DW running sum with synchronous clear (priority) and enable.
module byte_sum_acc
    import pattern_pkg::*;
#(
    parameter int unsigned DW = PAT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_sum
);

    logic [DW-1:0] r_sum;

    // Accumulate with natural wrap; clear wins over enable.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/pattern_writer.sv
// Loads DEPTH bytes from a valid/ready stream into the pattern memory and,
// optionally, reads them back to compare checksums.
module pattern_writer
    import pattern_pkg::*;
#(
    parameter int unsigned DEPTH  = PAT_DEPTH,
    parameter int unsigned AW     = PAT_AW,
    parameter int unsigned DW     = PAT_DW,
    parameter bit          VERIFY = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    pattern_writer_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int unsigned   CW        = AW + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    pw_state_t     r_state, w_state_nx;
    logic [CW-1:0] r_wcnt, w_wcnt_nx;
    logic [CW-1:0] r_rcnt, w_rcnt_nx;
    logic [AW-1:0] r_ptr, w_ptr_nx;
    logic [AW-1:0] r_addr, w_addr_nx;
    logic [DW-1:0] r_wdata, w_wdata_nx;
    logic          r_we, w_we_nx;
    logic          r_re, w_re_nx;
    logic          r_ce, w_ce_nx;
    logic          r_in_ready, w_ready_nx;
    logic          r_busy, w_busy_nx;
    logic          r_done, w_done_nx;
    logic          r_pass, w_pass_nx;
    logic          r_rvalid;

    logic          w_hs;
    logic          w_load_start;
    logic [DW-1:0] w_wsum;
    logic [DW-1:0] w_rsum;
    logic [DW-1:0] w_rsum_last;

    assign w_hs         = bus.in_valid && r_in_ready;
    assign w_load_start = (r_state == ST_IDLE) && start;
    // The final read is still in flight when DONE is decided, so fold it in here.
    assign w_rsum_last  = w_rsum + bus.RAM_rdata;

    byte_sum_acc #(.DW(DW)) u_wsum (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_load_start),
        .i_en   (w_hs),
        .i_data (bus.in_data),
        .o_sum  (w_wsum)
    );

    byte_sum_acc #(.DW(DW)) u_rsum (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_load_start),
        .i_en   (r_rvalid),
        .i_data (bus.RAM_rdata),
        .o_sum  (w_rsum)
    );

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        w_state_nx = r_state;
        w_wcnt_nx  = r_wcnt;
        w_rcnt_nx  = r_rcnt;
        w_ptr_nx   = r_ptr;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        w_we_nx    = 1'b0;
        w_re_nx    = 1'b0;
        w_pass_nx  = r_pass;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_WRITE;
                    w_wcnt_nx  = '0;
                    w_rcnt_nx  = '0;
                    w_ptr_nx   = '0;
                    w_pass_nx  = 1'b0;
                end
            end
            ST_WRITE: begin
                if (w_hs) begin
                    w_addr_nx  = r_ptr;
                    w_wdata_nx = bus.in_data;
                    w_we_nx    = 1'b1;
                    w_ptr_nx   = r_ptr + 1'b1;
                    w_wcnt_nx  = r_wcnt + 1'b1;
                end else if (r_wcnt == CNT_DEPTH) begin
                    // WRITE lingers one cycle after the last handshake so the
                    // final write completes before the phase changes.
                    if (VERIFY) begin
                        w_state_nx = ST_VERIFY;
                        w_re_nx    = 1'b1;
                        w_addr_nx  = '0;
                        w_ptr_nx   = AW'(1);
                        w_rcnt_nx  = CW'(1);
                    end else begin
                        w_state_nx = ST_DONE;
                        w_pass_nx  = 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                if (r_rcnt != CNT_DEPTH) begin
                    w_re_nx   = 1'b1;
                    w_addr_nx = r_ptr;
                    w_ptr_nx  = r_ptr + 1'b1;
                    w_rcnt_nx = r_rcnt + 1'b1;
                end else if (r_rvalid && !r_re) begin
                    w_state_nx = ST_DONE;
                    w_pass_nx  = (w_wsum == w_rsum_last);
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
        w_ready_nx = (w_state_nx == ST_WRITE) && (w_wcnt_nx != CNT_DEPTH);
        w_busy_nx  = (w_state_nx != ST_IDLE);
        w_done_nx  = (w_state_nx == ST_DONE);
        w_ce_nx    = w_we_nx | w_re_nx;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_ce       <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_wcnt     <= w_wcnt_nx;
            r_rcnt     <= w_rcnt_nx;
            r_ptr      <= w_ptr_nx;
            r_addr     <= w_addr_nx;
            r_wdata    <= w_wdata_nx;
            r_we       <= w_we_nx;
            r_re       <= w_re_nx;
            r_ce       <= w_ce_nx;
            r_in_ready <= w_ready_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
            r_pass     <= w_pass_nx;
            r_rvalid   <= r_re;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.RAM_addr  = r_addr;
    assign bus.RAM_wdata = r_wdata;
    assign bus.RAM_we    = r_we;
    assign bus.RAM_re    = r_re;
    assign bus.RAM_ce    = r_ce;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;

endmodule

// File: tb/tb_pattern_writer.sv
// Bench for pattern_writer: one instance with read-back verification and
// one without, each with its own synchronous RAM model, driven by random
// byte streams and compared cycle by cycle against a timeline model.
module tb_pattern_writer;
    import pattern_pkg::*;

    localparam int MAXCYC = 400;

    logic clk = 1'b0;
    logic reset;
    logic start_v, start_n;
    logic busy_v, done_v, pass_v;
    logic busy_n, done_n, pass_n;

    pattern_writer_if #(.AW(PAT_AW), .DW(PAT_DW)) bus_v ();
    pattern_writer_if #(.AW(PAT_AW), .DW(PAT_DW)) bus_n ();

    pattern_writer #(.DEPTH(PAT_DEPTH), .AW(PAT_AW), .DW(PAT_DW), .VERIFY(1'b1)) dut_v (
        .clk   (clk),
        .reset (reset),
        .start (start_v),
        .bus   (bus_v),
        .busy  (busy_v),
        .done  (done_v),
        .pass  (pass_v)
    );

    pattern_writer #(.DEPTH(PAT_DEPTH), .AW(PAT_AW), .DW(PAT_DW), .VERIFY(1'b0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .start (start_n),
        .bus   (bus_n),
        .busy  (busy_n),
        .done  (done_n),
        .pass  (pass_n)
    );

    always #5 clk = ~clk;

    // Memory models: 16 x 8, 1-cycle read latency, optional stuck address.
    logic [7:0] mem_v [16];
    logic [7:0] mem_n [16];
    logic [7:0] rdata_v, rdata_n;
    logic       fault_on;
    logic [3:0] fault_addr;
    logic [7:0] fault_val;

    always @(posedge clk) begin
        if (bus_v.RAM_we) mem_v[bus_v.RAM_addr] <= bus_v.RAM_wdata;
        if (bus_v.RAM_re)
            rdata_v <= (fault_on && bus_v.RAM_addr == fault_addr) ? fault_val : mem_v[bus_v.RAM_addr];
    end

    always @(posedge clk) begin
        if (bus_n.RAM_we) mem_n[bus_n.RAM_addr] <= bus_n.RAM_wdata;
        if (bus_n.RAM_re) rdata_n <= mem_n[bus_n.RAM_addr];
    end

    assign bus_v.RAM_rdata = rdata_v;
    assign bus_n.RAM_rdata = rdata_n;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         sel_n;
    logic [7:0] pat [16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        if (sel_n) begin
            bus_n.in_valid = v; bus_n.in_data = d; start_n = s;
            bus_v.in_valid = 1'b0; start_v = 1'b0;
        end else begin
            bus_v.in_valid = v; bus_v.in_data = d; start_v = s;
            bus_n.in_valid = 1'b0; start_n = 1'b0;
        end
    endtask

    task automatic sample(output logic busy, output logic done, output logic pass,
                          output logic rdy, output logic we, output logic re,
                          output logic ce, output logic [3:0] addr, output logic [7:0] wdata);
        if (sel_n) begin
            busy = busy_n; done = done_n; pass = pass_n; rdy = bus_n.in_ready;
            we = bus_n.RAM_we; re = bus_n.RAM_re; ce = bus_n.RAM_ce;
            addr = bus_n.RAM_addr; wdata = bus_n.RAM_wdata;
        end else begin
            busy = busy_v; done = done_v; pass = pass_v; rdy = bus_v.in_ready;
            we = bus_v.RAM_we; re = bus_v.RAM_re; ce = bus_v.RAM_ce;
            addr = bus_v.RAM_addr; wdata = bus_v.RAM_wdata;
        end
    endtask

    // One full load. gap_mode: 0 = valid always, 1 = valid on odd cycles, 2 = random.
    // The model: handshake k lands at the cycle it is offered while fewer than
    // 16 were taken; writes trail by one cycle; with L the last handshake cycle,
    // reads occupy L+2..L+17 and done lands at L+19 (L+2 without verify).
    task automatic run_load(input bit nv, input int gap_mode, input bit pulse_start,
                            output int done_cyc, output logic last_pass);
        logic a_busy, a_done, a_pass, a_rdy, a_we, a_re, a_ce;
        logic [3:0] a_addr;
        logic [7:0] a_wdata;
        int k, L, lat, c, prev_idx, n_done, wsum, rsum;
        bit prev_hs, v, s, exp_pass, exp_ready, exp_we, exp_re, exp_done, exp_busy, finished;
        logic [7:0] din;

        sel_n = nv;
        lat = nv ? 2 : 19;
        wsum = 0;
        for (int i = 0; i < 16; i++) wsum += int'(pat[i]);
        rsum = wsum;
        if (!nv && fault_on) rsum = wsum - int'(pat[fault_addr]) + int'(fault_val);
        exp_pass = nv ? 1'b1 : ((wsum % 256) == (rsum % 256));

        @(negedge clk);
        drive(1'b0, 8'h00, 1'b1);
        k = 0; L = -1; prev_hs = 0; prev_idx = 0; done_cyc = -1; n_done = 0;
        finished = 0; last_pass = 1'b0;
        for (c = 1; c < MAXCYC; c++) begin
            @(negedge clk);
            sample(a_busy, a_done, a_pass, a_rdy, a_we, a_re, a_ce, a_addr, a_wdata);
            exp_done  = (L >= 0) && (c == L + lat);
            exp_busy  = !((L >= 0) && (c > L + lat));
            exp_ready = (k < 16);
            exp_we    = prev_hs;
            exp_re    = !nv && (L >= 0) && (c >= L + 2) && (c <= L + 17);
            chk($sformatf("busy@%0d", c), a_busy, exp_busy);
            chk($sformatf("done@%0d", c), a_done, exp_done);
            chk($sformatf("rdy@%0d", c), a_rdy, exp_ready);
            chk($sformatf("we@%0d", c), a_we, exp_we);
            chk($sformatf("re@%0d", c), a_re, exp_re);
            chk($sformatf("ce@%0d", c), a_ce, exp_we | exp_re);
            chk($sformatf("pass@%0d", c), a_pass,
                ((L >= 0) && (c >= L + lat)) ? exp_pass : 1'b0);
            if (exp_we) begin
                chk($sformatf("waddr@%0d", c), a_addr, prev_idx);
                chk($sformatf("wdata@%0d", c), a_wdata, pat[prev_idx]);
            end
            if (exp_re) chk($sformatf("raddr@%0d", c), a_addr, c - (L + 2));
            if (a_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            last_pass = a_pass;
            if ((L >= 0) && (c == L + lat + 1)) begin
                finished = 1;
                break;
            end
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            din = (v && k < 16) ? pat[k] : 8'($urandom);
            s = pulse_start && ((c == 5) || ((L >= 0) && (c == L + 8)));
            drive(v, din, s);
            prev_hs = v && exp_ready;
            if (prev_hs) begin
                prev_idx = k;
                k++;
                if (k == 16) L = c;
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        if (!finished) chk("timeout", 0, 1);
        chk("ndone", n_done, 1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("mem[%0d]", i), nv ? mem_n[i] : mem_v[i], pat[i]);
    endtask

    task automatic run_reset_abort();
        logic a_busy, a_done, a_pass, a_rdy, a_we, a_re, a_ce;
        logic [3:0] a_addr;
        logic [7:0] a_wdata;
        sel_n = 1'b0;
        for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            drive(1'b1, pat[c-1], 1'b0);
            if (c == 8) reset = 1'b1;
        end
        @(negedge clk);
        sample(a_busy, a_done, a_pass, a_rdy, a_we, a_re, a_ce, a_addr, a_wdata);
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_rdy", a_rdy, 0);
        chk("rst_we", a_we, 0);
        chk("rst_re", a_re, 0);
        chk("rst_ce", a_ce, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_wdata", a_wdata, 0);
        for (int i = 0; i < 7; i++) chk($sformatf("partial[%0d]", i), mem_v[i], pat[i]);
        @(negedge clk);
        chk("rst_idle_busy", busy_v, 0);
        chk("rst_idle_rdy", bus_v.in_ready, 0);
    endtask

    initial begin
        int dc;
        logic lp;
        reset = 1'b1;
        start_v = 1'b0; start_n = 1'b0;
        bus_v.in_valid = 1'b0; bus_v.in_data = 8'h00;
        bus_n.in_valid = 1'b0; bus_n.in_data = 8'h00;
        fault_on = 1'b0; fault_addr = 4'd0; fault_val = 8'h00;
        sel_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy_v", busy_v, 0);
        chk("reset_done_v", done_v, 0);
        chk("reset_pass_v", pass_v, 0);
        chk("reset_rdy_v", bus_v.in_ready, 0);
        chk("reset_ce_v", bus_v.RAM_ce, 0);
        chk("reset_busy_n", busy_n, 0);
        chk("reset_pass_n", pass_n, 0);
        chk("reset_we_n", bus_n.RAM_we, 0);
        reset = 1'b0;
        @(negedge clk);

        // Ascending bytes, valid held high.
        for (int i = 0; i < 16; i++) pat[i] = 8'(i);
        run_load(1'b0, 0, 1'b0, dc, lp);
        chk("t1_done_cycle", dc, 35);
        chk("t1_pass", lp, 1);

        // Same bytes, valid every other cycle.
        run_load(1'b0, 1, 1'b0, dc, lp);
        chk("t2_pass", lp, 1);

        // Address 5 reads back 0xFF.
        fault_on = 1'b1; fault_addr = 4'd5; fault_val = 8'hFF;
        run_load(1'b0, 0, 1'b0, dc, lp);
        chk("t3_pass", lp, 0);
        fault_on = 1'b0;

        // Stray start pulses in WRITE and VERIFY.
        for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
        run_load(1'b0, 2, 1'b1, dc, lp);

        // Abort by reset, then a clean load.
        run_reset_abort();
        for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
        run_load(1'b0, 2, 1'b0, dc, lp);
        chk("t5_pass", lp, 1);

        // No-verify instance with constant 0xA5.
        for (int i = 0; i < 16; i++) pat[i] = 8'hA5;
        run_load(1'b1, 0, 1'b0, dc, lp);
        chk("t6_done_cycle", dc, 18);
        chk("t6_pass", lp, 1);

        // Random loads on both instances, occasional random fault.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
            fault_on   = 1'($urandom_range(0, 1));
            fault_addr = 4'($urandom);
            fault_val  = 8'($urandom);
            run_load(1'b0, 2, 1'($urandom_range(0, 1)), dc, lp);
            fault_on = 1'b0;
            for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
            run_load(1'b1, 2, 1'b0, dc, lp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule

// File: doc/pattern_writer.md
# pattern_writer

Programs the 16 x 8 pattern memory that the sensor block reads. Accepts a byte stream over a valid/ready handshake and writes it to consecutive addresses through the memory's address/data/enable interface. When verification is enabled, it then reads every location back and compares a modulo-256 checksum of the read data against one computed from the written data. It sits between the pattern-load source and the memory, and owns the memory port only while `busy` is high.

## Interface
- `DEPTH`, 16, number of locations written per load
- `AW`, 4, address width, equal to clog2(`DEPTH`)
- `DW`, 8, data width
- `VERIFY`, 1, 1 = read-back checksum pass after writing, 0 = skip it
- `clk` in 1: single system clock; memory is clocked by the same clock
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a load; sampled only in IDLE
- `in_data` in `DW`: pattern byte
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: byte accepted on a cycle where `in_valid` and `in_ready` are both high
- `RAM_addr` out `AW`: memory address
- `RAM_wdata` out `DW`: write data
- `RAM_rdata` in `DW`: read data, valid 1 cycle after `RAM_re`
- `RAM_we` out 1: write enable
- `RAM_re` out 1: read enable
- `RAM_ce` out 1: chip enable, equal to `RAM_we` | `RAM_re`
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at end of load
- `pass` out 1: result of the last load, held until the next `start`

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM returns to IDLE.
- States and transitions:
  - IDLE -> WRITE on `start`.
  - WRITE -> VERIFY after `DEPTH` handshakes, or -> DONE when `VERIFY`=0.
  - VERIFY -> DONE after `DEPTH` reads are issued and the last read is returned.
  - DONE -> IDLE unconditionally.
- IDLE: `in_ready`=0, so `in_valid` is ignored. `start` while not IDLE is ignored.
- WRITE: `in_ready`=1.
  - Each handshake registers `RAM_addr`=ptr, `RAM_wdata`=`in_data` and `RAM_we`=1 for the next cycle.
  - ptr increments, and `wsum` += `in_data` (mod 256).
  - `in_valid` gaps stall without penalty. `in_ready` drops in the cycle after the `DEPTH`th handshake.
- VERIFY: issues `DEPTH` back-to-back reads at addresses 0..`DEPTH`-1 with `RAM_re`=1. Each returned `RAM_rdata` is added to `rsum` (mod 256).
- DONE: `done`=1 for one cycle.
  - `pass` = (`wsum` == `rsum`) when `VERIFY`=1, else 1.
  - `pass` is cleared on `start`.
- `RAM_we` and `RAM_re` are never high together.
- ptr wraps from `DEPTH`-1 to 0 only at the phase boundary. A load always writes exactly `DEPTH` bytes.
- `wsum` and `rsum` are cleared on `start`.
- Reset mid-load aborts immediately: memory contents are left partially written, and `pass` becomes 0.

## Timing
- Cycle 0 is the cycle `start` is sampled. WRITE begins at cycle 1.
- With `in_valid` held high:
  - Handshakes occur in cycles 1..16.
  - `RAM_we` is high in cycles 2..17, addresses 0..15.
- `VERIFY`=1:
  - `RAM_re` is high in cycles 18..33.
  - `RAM_rdata` is sampled in cycles 19..34.
  - `done` is high in cycle 35.
- `VERIFY`=0: `done` is high in cycle 18.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Latency from the last handshake to `done`:
  - `VERIFY`=1: 19 cycles, fixed.
  - `VERIFY`=0: 2 cycles.

## Structure
- Shared package `pattern_pkg`:
  - State enum `pw_state_t` (IDLE, WRITE, VERIFY, DONE).
  - Constants `PAT_DEPTH`=16, `PAT_AW`=4, `PAT_DW`=8, which the parameters default to.
- One sub-module, `byte_sum_acc`: a mod-256 accumulator with clear and enable, instantiated twice (`wsum` and `rsum`).
- Testbench memory model: a 16 x 8 synchronous RAM with 1-cycle read latency and a fault-injection hook that forces one address to a fixed value.

## Test plan
- Load bytes 0x00..0x0F with `in_valid` held high, `VERIFY`=1 -> writes to addresses 0..15 in cycles 2..17; `done` in cycle 35; `pass`=1; memory holds 0x00..0x0F.
- Same load with `in_valid` low every other cycle -> 16 writes with no byte lost or duplicated, addresses strictly increasing; `pass`=1.
- Memory fault: address 5 reads back 0xFF while 0x05 was written -> `rsum` ≠ `wsum` (0x78 vs 0x78-0x05+0xFF); `done` with `pass`=0.
- `start` pulsed during WRITE and during VERIFY -> ignored; single `done`; byte count still 16.
- `reset` asserted in cycle 8 of a load -> next cycle all outputs are 0 and the FSM is IDLE; a fresh `start` completes a normal load with `pass`=1.
- `VERIFY`=0, bytes 0xA5 repeated 16 times -> `RAM_re` never asserted; `done` in cycle 18; `pass`=1.
